// File: rtl/calc_pkg.sv
// Shared types and line-level constants for the calculator serial transmitter.
package calc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_DONE    = 3'd5,
    S_RELEASE = 3'd6
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/calc_serial_tx_bit_timer.sv
// Per-bit cycle counter: bitEnd marks the last cycle of each serial bit.
module bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitEnd
);

  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign bitEnd = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || bitEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/calc_serial_tx.sv
// Framed LSB-first serial transmitter closing the controller's txData/txDone handshake.
module calc_serial_tx
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  txData,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  txOut,
  output logic                  txBusy,
  output logic                  txDone
);

  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t             r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shiftNext;
  logic [IW-1:0]         r_bitIdx, w_bitIdxNext;
  logic                  r_parity, w_parityNext;
  logic                  r_txOut, r_txBusy, r_txDone;
  logic                  w_txOutNext, w_txBusyNext, w_txDoneNext;
  logic                  w_bitEnd, w_clear;

  assign w_clear = (w_next != r_state);

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .bitEnd(w_bitEnd)
  );

  always_comb begin
    w_next       = r_state;
    w_shiftNext  = r_shift;
    w_bitIdxNext = r_bitIdx;
    w_parityNext = r_parity;
    case (r_state)
      S_IDLE: begin
        if (txData) begin
          w_next       = S_START;
          w_shiftNext  = dataIn;
          w_bitIdxNext = '0;
          w_parityNext = ^dataIn;
        end
      end
      S_START:  if (w_bitEnd) w_next = S_DATA;
      S_DATA: begin
        if (w_bitEnd) begin
          w_shiftNext = r_shift >> 1;
          if (r_bitIdx == LAST_IDX) begin
            w_bitIdxNext = '0;
            w_next       = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + IW'(1);
          end
        end
      end
      S_PARITY: if (w_bitEnd) w_next = S_STOP;
      S_STOP:   if (w_bitEnd) w_next = S_DONE;
      S_DONE:   w_next = S_RELEASE;
      S_RELEASE: if (!txData) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line lines up with the state register.
  always_comb begin
    w_txOutNext = LINE_IDLE;
    case (w_next)
      S_START:  w_txOutNext = START_BIT;
      S_DATA:   w_txOutNext = w_shiftNext[0];
      S_PARITY: w_txOutNext = w_parityNext;
      S_STOP:   w_txOutNext = STOP_BIT;
      default:  w_txOutNext = LINE_IDLE;
    endcase
    w_txBusyNext = (w_next == S_START) || (w_next == S_DATA) ||
                   (w_next == S_PARITY) || (w_next == S_STOP);
    w_txDoneNext = (w_next == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_parity <= 1'b0;
      r_txOut  <= LINE_IDLE;
      r_txBusy <= 1'b0;
      r_txDone <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_shift  <= w_shiftNext;
      r_bitIdx <= w_bitIdxNext;
      r_parity <= w_parityNext;
      r_txOut  <= w_txOutNext;
      r_txBusy <= w_txBusyNext;
      r_txDone <= w_txDoneNext;
    end
  end

  assign txOut  = r_txOut;
  assign txBusy = r_txBusy;
  assign txDone = r_txDone;

endmodule

// File: tb/tb_calc_serial_tx.sv
// Scoreboard bench for calc_serial_tx over three parameter sets.
module tb_calc_serial_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       txA, outA, busyA, doneA;
  logic [7:0] dA;
  logic       txP, outP, busyP, doneP;
  logic [7:0] dP;
  logic       txB, outB, busyB, doneB;
  logic [3:0] dB;

  calc_serial_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(0)) u_a (
    .clk(clk), .reset(reset), .txData(txA), .dataIn(dA),
    .txOut(outA), .txBusy(busyA), .txDone(doneA));

  calc_serial_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1)) u_p (
    .clk(clk), .reset(reset), .txData(txP), .dataIn(dP),
    .txOut(outP), .txBusy(busyP), .txDone(doneP));

  calc_serial_tx #(.DATA_WIDTH(4), .BIT_CYCLES(1), .PARITY_EN(0)) u_b (
    .clk(clk), .reset(reset), .txData(txB), .dataIn(dB),
    .txOut(outB), .txBusy(busyB), .txDone(doneB));

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];

  task automatic push_bits(input logic [31:0] w, input int dw, input int bc, input bit par);
    logic p;
    p = 1'b0;
    for (int b = 0; b < bc; b++) exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      p = p ^ w[i];
      for (int b = 0; b < bc; b++) exp_q.push_back(w[i]);
    end
    if (par) for (int b = 0; b < bc; b++) exp_q.push_back(p);
    for (int b = 0; b < bc; b++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    txA = 1'b0; dA = '0; txP = 1'b0; dP = '0; txB = 1'b0; dB = '0;
    #2;
    n_cmp++; if (outA !== 1'b1) begin n_err++; $display("FAIL reset_txOut: got %b want 1", outA); end
    n_cmp++; if (busyA !== 1'b0) begin n_err++; $display("FAIL reset_txBusy: got %b want 0", busyA); end
    n_cmp++; if (doneA !== 1'b0) begin n_err++; $display("FAIL reset_txDone: got %b want 0", doneA); end
    n_cmp++; if (outP !== 1'b1 || outB !== 1'b1) begin
      n_err++; $display("FAIL reset_txOut_others: got %b%b want 11", outP, outB);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (outA !== 1'b1 || busyA !== 1'b0) begin
      n_err++; $display("FAIL idle_line: got out=%b busy=%b want out=1 busy=0", outA, busyA);
    end
  endtask

  task automatic test_basic;
    logic e;
    @(negedge clk);
    dA = 8'hA5; txA = 1'b1;
    push_bits(32'hA5, 8, 4, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outA !== e) begin n_err++; $display("FAIL basic_bit%0d: got %b want %b", i, outA, e); end
      n_cmp++; if (busyA !== 1'b1 || doneA !== 1'b0) begin
        n_err++; $display("FAIL basic_busy%0d: got busy=%b done=%b want busy=1 done=0", i, busyA, doneA);
      end
    end
    @(negedge clk);
    n_cmp++; if (doneA !== 1'b1 || busyA !== 1'b0 || outA !== 1'b1) begin
      n_err++; $display("FAIL basic_done: got done=%b busy=%b out=%b want 1 0 1", doneA, busyA, outA);
    end
  endtask

  task automatic test_held_request;
    logic e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++; if (outA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) begin
        n_err++; $display("FAIL held_quiet%0d: got out=%b busy=%b done=%b want 1 0 0", i, outA, busyA, doneA);
      end
    end
    txA = 1'b0;
    @(negedge clk);
    n_cmp++; if (outA !== 1'b1) begin n_err++; $display("FAIL held_idle: got %b want 1", outA); end
    dA = 8'h3C; txA = 1'b1;
    push_bits(32'h3C, 8, 4, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outA !== e) begin n_err++; $display("FAIL restart_bit%0d: got %b want %b", i, outA, e); end
    end
    @(negedge clk);
    n_cmp++; if (doneA !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", doneA); end
    txA = 1'b0;
  endtask

  task automatic test_data_change;
    logic e;
    repeat (3) @(negedge clk);
    dA = 8'h0F; txA = 1'b1;
    push_bits(32'h0F, 8, 4, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outA !== e) begin n_err++; $display("FAIL chg_bit%0d: got %b want %b", i, outA, e); end
      if (i == 13) dA = 8'hF0;
      if (i == 20) txA = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (doneA !== 1'b1) begin n_err++; $display("FAIL chg_done: got %b want 1", doneA); end
  endtask

  task automatic test_reset_mid;
    logic e;
    repeat (3) @(negedge clk);
    dA = 8'h55; txA = 1'b1;
    push_bits(32'h55, 8, 4, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outA !== e) begin n_err++; $display("FAIL rst_pre_bit%0d: got %b want %b", i, outA, e); end
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (outA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_async: got out=%b busy=%b done=%b want 1 0 0", outA, busyA, doneA);
    end
    exp_q.delete();
    #2 reset = 1'b0;
    push_bits(32'h55, 8, 4, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outA !== e) begin n_err++; $display("FAIL rst_post_bit%0d: got %b want %b", i, outA, e); end
    end
    @(negedge clk);
    n_cmp++; if (doneA !== 1'b1) begin n_err++; $display("FAIL rst_post_done: got %b want 1", doneA); end
    txA = 1'b0;
  endtask

  task automatic test_parity;
    logic e;
    @(negedge clk);
    dP = 8'h07; txP = 1'b1;
    push_bits(32'h07, 8, 1, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (outP !== e || busyP !== 1'b1) begin
        n_err++; $display("FAIL par_bit%0d: got out=%b busy=%b want out=%b busy=1", i, outP, busyP, e);
      end
      if (i == 9) begin
        n_cmp++; if (outP !== 1'b1) begin n_err++; $display("FAIL par_value: got %b want 1", outP); end
      end
    end
    @(negedge clk);
    n_cmp++; if (doneP !== 1'b1 || busyP !== 1'b0) begin
      n_err++; $display("FAIL par_done: got done=%b busy=%b want 1 0", doneP, busyP);
    end
    txP = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic e;
    int   k;
    int   k2;
    bit   seen;
    k = 0; k2 = 0; seen = 1'b0;
    @(negedge clk);
    dB = 4'h9; txB = 1'b1;
    push_bits(32'h9, 4, 1, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) k = cyc;
      e = exp_q.pop_front();
      n_cmp++; if (outB !== e) begin n_err++; $display("FAIL b2b_f1_bit%0d: got %b want %b", i, outB, e); end
    end
    @(negedge clk);
    n_cmp++; if (doneB !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", doneB); end
    txB = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dB = 4'h6; txB = 1'b1;
    push_bits(32'h6, 4, 1, 1'b0);
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (busyB === 1'b1) begin seen = 1'b1; k2 = cyc; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL b2b_accept_timeout: got no busy want busy within 20 cycles");
      exp_q.delete();
    end else begin
      if (k2 - k !== 9) begin n_err++; $display("FAIL b2b_accept_edge: got k+%0d want k+9", k2 - k); end
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++; if (outB !== e) begin n_err++; $display("FAIL b2b_f2_bit%0d: got %b want %b", i, outB, e); end
      end
      @(negedge clk);
      n_cmp++; if (doneB !== 1'b1) begin n_err++; $display("FAIL b2b_f2_done: got %b want 1", doneB); end
    end
    txB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_held_request();
    test_data_change();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
